servile_rr_arbiter: RTL

Parametrised N-master round-robin Wishbone arbiter for the servile memory port, generalising the fixed two-master (ibus/dbus) arbiter. It lets any number of bus masters (CPU ibus, CPU dbus, DMA, debug) share one single-ported memory slave. A small grant state machine provides fair round-robin selection and holds each grant until the transaction completes or is abandoned. An optional watchdog terminates hung transactions.

---
 rtl/servile_rr_arbiter.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/servile_rr_arbiter.sv
// N-master round-robin Wishbone arbiter: one IDLE arbitration cycle per grant, then the grant is held until ack or abandon.
// Optional hung-transaction watchdog: SERVILE_ARB_TIMEOUT_EN.
module servile_rr_arbiter #(
   parameter int masters = 2,
   parameter int timeout = 255,
   parameter int gw      = $clog2(masters)
) (
   input  logic                  i_clk,
   input  logic                  i_rst,
   input  logic [masters*32-1:0] i_wb_m_adr,
   input  logic [masters*32-1:0] i_wb_m_dat,
   input  logic [masters*4-1:0]  i_wb_m_sel,
   input  logic [masters-1:0]    i_wb_m_we,
   input  logic [masters-1:0]    i_wb_m_stb,
   output logic [31:0]           o_wb_m_rdt,
   output logic [masters-1:0]    o_wb_m_ack,
   output logic [31:0]           o_wb_s_adr,
   output logic [31:0]           o_wb_s_dat,
   output logic [3:0]            o_wb_s_sel,
   output logic                  o_wb_s_we,
   output logic                  o_wb_s_stb,
   input  logic [31:0]           i_wb_s_rdt,
   input  logic                  i_wb_s_ack,
   output logic [gw-1:0]         o_grant,
   output logic                  o_busy,
   output logic                  o_timeout
);

   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] BUSY = 1'b1;

   logic [0:0]            state_q, state_d;
   logic [gw-1:0]         last_q, last_d;
   logic                  in_busy;
   logic                  sel_stb;
   logic                  to_hit;
   logic                  found;
   int                    idx;
   logic [masters*32-1:0] adr_sh, dat_sh;
   logic [masters*4-1:0]  sel_sh;
   logic [masters-1:0]    we_sh, stb_sh, stb_rot;

   assign in_busy   = (state_q == BUSY);
   assign o_busy    = in_busy;
   assign o_grant   = last_q;

   // Shift the granted slice down to bit 0 rather than indexing with a variable part-select.
   assign adr_sh  = i_wb_m_adr >> (32 * int'(last_q));
   assign dat_sh  = i_wb_m_dat >> (32 * int'(last_q));
   assign sel_sh  = i_wb_m_sel >> (4 * int'(last_q));
   assign we_sh   = i_wb_m_we  >> last_q;
   assign stb_sh  = i_wb_m_stb >> last_q;
   assign sel_stb = stb_sh[0];

`ifdef SERVILE_ARB_TIMEOUT_EN
   localparam int cw_raw = $clog2(timeout + 1);
   localparam int cw     = (cw_raw < 8) ? 8 : ((cw_raw > 32) ? 32 : cw_raw);

   logic [cw-1:0] cnt_q, cnt_d;
   logic          to_q, to_d;

   // cnt_q counts earlier ack-less BUSY cycles, so cnt_q+1 is this cycle's count.
   assign to_hit    = in_busy && sel_stb && !i_wb_s_ack && (cnt_q == cw'(timeout - 1));
   assign o_timeout = to_q;

   always_comb begin
      cnt_d = cnt_q;
      to_d  = to_q | to_hit;
      if (!in_busy)
         cnt_d = '0;
      else if (!i_wb_s_ack)
         cnt_d = cnt_q + 1'b1;
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         cnt_q <= '0;
         to_q  <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         to_q  <= to_d;
      end
   end
`else
   assign to_hit    = 1'b0;
   assign o_timeout = 1'b0;
`endif

   always_comb begin
      o_wb_s_adr = '0;
      o_wb_s_dat = '0;
      o_wb_s_sel = '0;
      o_wb_s_we  = 1'b0;
      o_wb_s_stb = 1'b0;
      o_wb_m_rdt = '0;
      o_wb_m_ack = '0;
      if (in_busy) begin
         o_wb_s_adr = adr_sh[31:0];
         o_wb_s_dat = dat_sh[31:0];
         o_wb_s_sel = sel_sh[3:0];
         o_wb_s_we  = we_sh[0];
         o_wb_s_stb = sel_stb & ~to_hit;
         if (i_wb_s_ack)
            o_wb_m_rdt = i_wb_s_rdt;
         if (i_wb_s_ack || to_hit)
            o_wb_m_ack = {{(masters-1){1'b0}}, 1'b1} << last_q;
      end
   end

   always_comb begin
      state_d = state_q;
      last_d  = last_q;
      found   = 1'b0;
      idx     = 0;
      stb_rot = '0;
      if (state_q == IDLE) begin
         for (int i = 1; i <= masters; i++) begin
            idx = int'(last_q) + i;
            if (idx >= masters)
               idx = idx - masters;
            stb_rot = i_wb_m_stb >> idx;
            if (!found && stb_rot[0]) begin
               found  = 1'b1;
               last_d = gw'(idx);
            end
         end
         if (found)
            state_d = BUSY;
      end else if (i_wb_s_ack || !sel_stb || to_hit) begin
         state_d = IDLE;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q <= IDLE;
         last_q  <= gw'(masters - 1);
      end else begin
         state_q <= state_d;
         last_q  <= last_d;
      end
   end

endmodule
